// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory slave with a fixed number of wait
// states per access and a one-cycle ready strobe on completion.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN. When defined, accesses with
// address bits above the index range are flagged with err, stores are dropped
// and loads return 0. When undefined, the address wraps modulo DEPTH.
module dmem_responder #(
    parameter int DEPTH       = 4096,
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic        ready,
    output logic [31:0] q_dmem,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter reload value; a zero-wait build never enters WAIT, so 0 is harmless.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wren_q, wren_d;
    logic                oob_q, oob_d;
    logic [31:0]         q_q, q_d;
    logic                err_q, err_d;

    // Operands of the access committed this cycle. A zero-wait build commits on
    // the capture edge itself, so these come straight from the inputs in IDLE.
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_wdata;
    logic                acc_wren;
    logic                acc_oob;
    logic                access;
    logic                mem_we;
    logic                in_oob;

    // Storage has no reset: contents survive a reset pulse.
    logic [31:0]         mem [DEPTH];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_oob = |address_dmem[31:ADDR_W];
`else
    // Upper address bits are ignored; the index wraps modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address_dmem[31:ADDR_W];
    assign in_oob         = 1'b0;
`endif

    // Next-state, capture and access decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wren_d    = wren_q;
        oob_d     = oob_q;
        q_d       = q_q;
        err_d     = 1'b0;
        access    = 1'b0;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_wren  = wren_q;
        acc_oob   = oob_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d     = address_dmem[ADDR_W-1:0];
                    wdata_d   = data;
                    wren_d    = wren;
                    oob_d     = in_oob;
                    acc_idx   = address_dmem[ADDR_W-1:0];
                    acc_wdata = data;
                    acc_wren  = wren;
                    acc_oob   = in_oob;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Out-of-range accesses report err and return 0 instead of touching memory.
        if (access) begin
            if (acc_oob) begin
                q_d   = 32'd0;
                err_d = 1'b1;
            end else if (acc_wren) begin
                q_d = acc_wdata;
            end else begin
                q_d = mem[acc_idx];
            end
        end

        mem_we = access && acc_wren && !acc_oob;
    end

    // Control and result registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wren_q  <= 1'b0;
            oob_q   <= 1'b0;
            q_q     <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            oob_q   <= oob_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    // Memory write port; only commits on the edge entering DONE.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign ready  = (state_q == DONE);
    assign q_dmem = q_q;
    assign err    = err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of 32-bit words stored.
REQ-002 SHALL have parameter ADDR_W, default 12, index width, with DEPTH = 2^ADDR_W.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (0..15).
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-006 SHALL have port req, input, 1, access request from the processor data port.
REQ-007 SHALL have port address_dmem, input, 32, word address.
REQ-008 SHALL have port data, input, 32, store data.
REQ-009 SHALL have port wren, input, 1, 1 = store, 0 = load.
REQ-010 SHALL have port ready, output, 1, one-cycle completion strobe.
REQ-011 SHALL have port q_dmem, output, 32, load result, or the stored word for a store.
REQ-012 SHALL have port err, output, 1, out-of-range flag, valid while ready = 1.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-014 SHALL sample req only in IDLE; req = 1 captures address_dmem, data and wren into internal registers at that edge.
REQ-015 SHALL transition IDLE->WAIT on capture when WAIT_CYCLES > 0, and IDLE->DONE when WAIT_CYCLES = 0.
REQ-016 SHALL load the wait counter with WAIT_CYCLES-1 on capture, decrement it each WAIT cycle, and go WAIT->DONE when it reads 0.
REQ-017 SHALL perform the array access on the edge entering DONE: a store writes the captured data and sets q_dmem to it; a load sets q_dmem to the array word.
REQ-018 SHALL assert ready only in DONE, for exactly one cycle, then go DONE->IDLE unconditionally.
REQ-019 SHALL give latency from the capture edge to ready high of WAIT_CYCLES+1 cycles (3 at default).
REQ-020 SHALL ignore req, address_dmem, data and wren in WAIT and DONE; input changes mid-access do not alter the access.
REQ-021 SHALL treat req still high in IDLE after DONE as a new request; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-022 SHALL hold q_dmem stable between completions.
REQ-023 SHALL drive err to 0 outside DONE.
REQ-024 SHALL make a load immediately following a store to the same address return the stored value.

Reset
REQ-025 SHALL, while reset = 0, force IDLE, ready = 0, q_dmem = 0, err = 0 and counter = 0, independent of clock.
REQ-026 SHALL, on reset asserted in WAIT, abort the access; an uncommitted store is discarded.
REQ-027 SHALL NOT reset array contents; contents are undefined after power-up and preserved across reset.
REQ-028 SHALL accept a request on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL use macro DMEM_BOUNDS_CHECK_EN.
REQ-030 SHALL, when DMEM_BOUNDS_CHECK_EN is defined, flag any access with address_dmem[31:ADDR_W] != 0: the store is suppressed, a load returns 0, and err = 1 in DONE.
REQ-031 SHALL, when DMEM_BOUNDS_CHECK_EN is undefined, index with address_dmem[ADDR_W-1:0] (wrap modulo DEPTH) and tie err to 0.

Verification
REQ-032 SHALL cover: reset low, then high; store req at address 5, data 0xDEADBEEF -> ready high exactly 3 cycles after capture; q_dmem = 0xDEADBEEF; err = 0.
REQ-033 SHALL cover: load address 5 immediately after REQ-032 -> ready after 3 cycles; q_dmem = 0xDEADBEEF.
REQ-034 SHALL cover: during WAIT, change address_dmem to 9 and wren to 1 -> the original access completes unchanged and word 9 is not modified.
REQ-035 SHALL cover: store address 7 = 0x12345678, then reset pulsed low in WAIT -> ready never asserts; q_dmem = 0; a later load of 7 returns its prior value, not 0x12345678.
REQ-036 SHALL cover: with DMEM_BOUNDS_CHECK_EN, store 0x0000_1005 = 0xFFFF_FFFF -> err = 1 and word 5 unchanged; without the macro -> err = 0 and word 5 = 0xFFFF_FFFF.
REQ-037 SHALL cover: with WAIT_CYCLES = 0, req held high -> ready every 2nd cycle, latency 1, q_dmem updated each completion.
